// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IF_WAIT   = 2'd1,
      D_WAIT    = 2'd2,
      KILL_WAIT = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_src_e;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, LSU and memory-side signals of the unified memory port arbiter.
interface mem_port_arbiter_if #(
   parameter int Width = 32
);

   logic             if_req_i;
   logic [Width-1:0] if_addr_i;
   logic             if_kill_i;
   logic [Width-1:0] if_rdata_o;
   logic             if_valid_o;
   logic             if_stall_o;

   logic             d_req_i;
   logic             d_we_i;
   logic [3:0]       d_be_i;
   logic [Width-1:0] d_addr_i;
   logic [Width-1:0] d_wdata_i;
   logic [Width-1:0] d_rdata_o;
   logic             d_valid_o;
   logic             d_stall_o;

   logic             mem_req_o;
   logic             mem_we_o;
   logic [3:0]       mem_be_o;
   logic [Width-1:0] mem_addr_o;
   logic [Width-1:0] mem_wdata_o;
   logic [Width-1:0] mem_rdata_i;
   logic             mem_ack_i;

   logic             err_timeout_o;

   // arbiter side
   modport slave (
      input  if_req_i, if_addr_i, if_kill_i,
      input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      input  mem_rdata_i, mem_ack_i,
      output if_rdata_o, if_valid_o, if_stall_o,
      output d_rdata_o, d_valid_o, d_stall_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output err_timeout_o
   );

   // requesters plus memory
   modport master (
      output if_req_i, if_addr_i, if_kill_i,
      output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      output mem_rdata_i, mem_ack_i,
      input  if_rdata_o, if_valid_o, if_stall_o,
      input  d_rdata_o, d_valid_o, d_stall_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  err_timeout_o
   );

endinterface

// File: rtl/mem_arb_wdog.sv
// Watchdog: counts cycles while run is high and flags the last allowed cycle.
module mem_arb_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (run && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // high during the TIMEOUT-th waiting cycle; abort happens on the following edge
   assign expired = run & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and LSU accesses onto one single-ported memory.
//
// state     | meaning
// IDLE      | no transaction; arbitrate and latch the winner
// IF_WAIT   | fetch on the bus, waiting for mem_ack_i
// D_WAIT    | load/store on the bus, waiting for mem_ack_i
// KILL_WAIT | flushed fetch still on the bus; result will be dropped
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int Width     = 32,
   parameter int TIMEOUT   = 255,
   parameter int IF_STARVE = 4
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   mem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(IF_STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE);

   arb_state_e       state_q, state_d;
   grant_src_e       gnt_src;
   logic             grant;
   logic             fetch_elig;
   logic             starved;
   logic             in_wait;
   logic             done;
   logic             wd_expired;

   logic [Width-1:0] addr_q;
   logic [Width-1:0] wdata_q;
   logic [3:0]       be_q;
   logic             we_q;
   logic [SW-1:0]    starve_q;

   logic [Width-1:0] if_rdata_q;
   logic             if_valid_q;
   logic [Width-1:0] d_rdata_q;
   logic             d_valid_q;
   logic             err_q;

   assign in_wait = (state_q != IDLE);
   assign done    = bus.mem_ack_i | wd_expired;

   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .run     (in_wait),
      .clear   (~in_wait),
      .expired (wd_expired)
   );

   // arbitration: data wins unless fetch has been passed over IF_STARVE times
   always_comb begin
      fetch_elig = bus.if_req_i & ~bus.if_kill_i;
      starved    = (starve_q == STARVE_MAX);
      grant      = 1'b0;
      gnt_src    = GNT_D;
      if (state_q == IDLE) begin
         if (bus.d_req_i && !(fetch_elig && starved)) begin
            grant   = 1'b1;
            gnt_src = GNT_D;
         end else if (fetch_elig) begin
            grant   = 1'b1;
            gnt_src = GNT_IF;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = (gnt_src == GNT_IF) ? IF_WAIT : D_WAIT;
            end
         end
         IF_WAIT: begin
            if (done) begin
               state_d = IDLE;
            end else if (bus.if_kill_i) begin
               state_d = KILL_WAIT;
            end
         end
         D_WAIT, KILL_WAIT: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req_o     = in_wait;
      bus.mem_we_o      = (state_q == D_WAIT) & we_q;
      bus.mem_be_o      = in_wait ? be_q : 4'h0;
      bus.mem_addr_o    = in_wait ? addr_q : '0;
      bus.mem_wdata_o   = in_wait ? wdata_q : '0;
      bus.if_rdata_o    = if_rdata_q;
      bus.if_valid_o    = if_valid_q;
      bus.d_rdata_o     = d_rdata_q;
      bus.d_valid_o     = d_valid_q;
      bus.err_timeout_o = err_q;
      bus.if_stall_o    = bus.if_req_i & ~if_valid_q & ~bus.if_kill_i;
      bus.d_stall_o     = bus.d_req_i & ~d_valid_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= 4'h0;
         we_q       <= 1'b0;
         starve_q   <= '0;
      end else begin
         if (grant) begin
            if (gnt_src == GNT_IF) begin
               addr_q  <= bus.if_addr_i;
               wdata_q <= '0;
               be_q    <= BE_FULL;
               we_q    <= 1'b0;
            end else begin
               addr_q  <= bus.d_addr_i;
               wdata_q <= bus.d_wdata_i;
               be_q    <= bus.d_be_i;
               we_q    <= bus.d_we_i;
            end
         end
         if (state_q == IDLE) begin
            if (!bus.if_req_i || (grant && gnt_src == GNT_IF)) begin
               starve_q <= '0;
            end else if (grant && !starved) begin
               starve_q <= starve_q + SW'(1);
            end
         end
      end
   end

   // completion; a watchdog abort returns zero data to the waiting port
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         if_rdata_q <= '0;
         if_valid_q <= 1'b0;
         d_rdata_q  <= '0;
         d_valid_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if (done) begin
            unique case (state_q)
               IF_WAIT: begin
                  if (!bus.if_kill_i) begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
                  end
               end
               D_WAIT: begin
                  d_valid_q <= 1'b1;
                  d_rdata_q <= (bus.mem_ack_i && !we_q) ? bus.mem_rdata_i : '0;
               end
               default: ;
            endcase
         end
         if (wd_expired && !bus.mem_ack_i) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation, kill, timeout, reset.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.Width(32)) bus ();

   mem_port_arbiter #(
      .Width     (32),
      .TIMEOUT   (8),
      .IF_STARVE (4)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = '0;
      bus.if_kill_i   = 1'b0;
      bus.d_req_i     = 1'b0;
      bus.d_we_i      = 1'b0;
      bus.d_be_i      = 4'h0;
      bus.d_addr_i    = '0;
      bus.d_wdata_i   = '0;
      bus.mem_rdata_i = '0;
      bus.mem_ack_i   = 1'b0;

      // reset
      tick(); tick(); tick();
      chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
      chk("rst_err", 32'(bus.err_timeout_o), 32'd0);
      chk("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
      chk("rst_d_valid", 32'(bus.d_valid_o), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;

      // fetch only, ack in first cycle
      tick();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h0050_0093;
      #1;
      chk("f_stall_t", 32'(bus.if_stall_o), 32'd1);
      chk("f_req_t", 32'(bus.mem_req_o), 32'd0);
      tick(); #1;
      chk("f_req_t1", 32'(bus.mem_req_o), 32'd1);
      chk("f_addr_t1", bus.mem_addr_o, 32'h100);
      chk("f_be_t1", 32'(bus.mem_be_o), 32'hF);
      chk("f_we_t1", 32'(bus.mem_we_o), 32'd0);
      chk("f_stall_t1", 32'(bus.if_stall_o), 32'd1);
      tick();
      chk("f_valid_t2", 32'(bus.if_valid_o), 32'd1);
      chk("f_rdata_t2", bus.if_rdata_o, 32'h0050_0093);
      chk("f_stall_t2", 32'(bus.if_stall_o), 32'd0);
      bus.if_req_i = 1'b0;
      tick(); #1;
      chk("f_valid_t3", 32'(bus.if_valid_o), 32'd0);
      chk("f_req_t3", 32'(bus.mem_req_o), 32'd0);

      // simultaneous store and fetch: data first
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
      bus.d_addr_i = 32'h7F0; bus.d_wdata_i = 32'hDEAD_BEEF;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
      #1;
      chk("s_dstall_t", 32'(bus.d_stall_o), 32'd1);
      tick();
      bus.d_addr_i = 32'h999;
      #1;
      chk("s_we_t1", 32'(bus.mem_we_o), 32'd1);
      chk("s_be_t1", 32'(bus.mem_be_o), 32'h3);
      chk("s_addr_t1", bus.mem_addr_o, 32'h7F0);
      chk("s_wdata_t1", bus.mem_wdata_o, 32'hDEAD_BEEF);
      tick();
      chk("s_dvalid_t2", 32'(bus.d_valid_o), 32'd1);
      chk("s_drdata_t2", bus.d_rdata_o, 32'h0);
      bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
      tick(); #1;
      chk("s_faddr_t3", bus.mem_addr_o, 32'h104);
      chk("s_fwe_t3", 32'(bus.mem_we_o), 32'd0);
      chk("s_fbe_t3", 32'(bus.mem_be_o), 32'hF);
      tick();
      chk("s_fvalid_t4", 32'(bus.if_valid_o), 32'd1);
      chk("s_frdata_t4", bus.if_rdata_o, 32'h1234_5678);
      bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b0;

      // starvation guard: four loads, then the fetch is forced
      tick();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h300;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hA5A5_0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("st_daddr", bus.mem_addr_o, 32'h300);
         tick();
         chk("st_dvalid", 32'(bus.d_valid_o), 32'd1);
         chk("st_drdata", bus.d_rdata_o, 32'hA5A5_0001);
      end
      tick();
      chk("st_faddr", bus.mem_addr_o, 32'h200);
      chk("st_cnt", 32'(dut.starve_q), 32'd0);
      tick();
      chk("st_fvalid", 32'(bus.if_valid_o), 32'd1);
      chk("st_dvalid_off", 32'(bus.d_valid_o), 32'd0);
      bus.if_req_i = 1'b0; bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;

      // kill during IF_WAIT, pending load afterwards
      tick();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h400;
      tick();
      bus.if_kill_i = 1'b1;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h500;
      #1;
      chk("k_ifstall", 32'(bus.if_stall_o), 32'd0);
      chk("k_dstall", 32'(bus.d_stall_o), 32'd1);
      tick();
      bus.if_kill_i = 1'b0; bus.if_req_i = 1'b0;
      #1;
      chk("k_state", 32'(dut.state_q), 32'(KILL_WAIT));
      chk("k_addr", bus.mem_addr_o, 32'h400);
      tick();
      tick();
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_0001;
      tick();
      chk("k_ifvalid_ack", 32'(bus.if_valid_o), 32'd0);
      chk("k_state_idle", 32'(dut.state_q), 32'(IDLE));
      bus.mem_rdata_i = 32'h0000_BEEF;
      tick();
      chk("k_daddr", bus.mem_addr_o, 32'h500);
      chk("k_ifvalid_late", 32'(bus.if_valid_o), 32'd0);
      tick();
      chk("k_dvalid", 32'(bus.d_valid_o), 32'd1);
      chk("k_drdata", bus.d_rdata_o, 32'h0000_BEEF);
      bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;

      // watchdog: no ack for TIMEOUT=8 cycles
      tick();
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h600; bus.mem_rdata_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("w_req", 32'(bus.mem_req_o), 32'd1);
         chk("w_err_early", 32'(bus.err_timeout_o), 32'd0);
      end
      tick();
      chk("w_err", 32'(bus.err_timeout_o), 32'd1);
      chk("w_dvalid", 32'(bus.d_valid_o), 32'd1);
      chk("w_drdata", bus.d_rdata_o, 32'h0);
      bus.d_req_i = 1'b0;
      tick();
      chk("w_err_sticky", 32'(bus.err_timeout_o), 32'd1);
      chk("w_dvalid_off", 32'(bus.d_valid_o), 32'd0);
      chk("w_state", 32'(dut.state_q), 32'(IDLE));

      // reset during D_WAIT, then a late ack
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h700;
      tick();
      chk("r_req", 32'(bus.mem_req_o), 32'd1);
      chk("r_err_before", 32'(bus.err_timeout_o), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b1;
      #1;
      chk("r_mem_req", 32'(bus.mem_req_o), 32'd0);
      chk("r_mem_addr", bus.mem_addr_o, 32'h0);
      chk("r_err", 32'(bus.err_timeout_o), 32'd0);
      chk("r_dvalid", 32'(bus.d_valid_o), 32'd0);
      chk("r_state", 32'(dut.state_q), 32'(IDLE));
      tick();
      chk("r_dvalid_late", 32'(bus.d_valid_o), 32'd0);
      chk("r_ifvalid_late", 32'(bus.if_valid_o), 32'd0);
      chk("r_mem_req_late", 32'(bus.mem_req_o), 32'd0);
      bus.mem_ack_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
